irq_ctrl: RTL and testbench
===========================

Name: irq_ctrl

Overview:
- Prioritised interrupt controller. It merges N external interrupt sources into the single `interrupt` input of the CPU.
- It snoops the CPU→RAM bus (wrEn/addr_toRAM/data_toRAM) for three events:
  - writes to a mask register address;
  - the CPU's ISR-entry return-PC save at address 21;
  - writes to an end-of-interrupt (EOI) address.
- It sits beside the CPU and blram. The RAM still receives every snooped write; the controller never drives the RAM.

Parameters:
- N_SRC, 8, number of interrupt sources (1..16)
- ID_W, 3, width of the source index; must be ≥ clog2(N_SRC)
- SAVE_ADDR, 14'h0015, address the CPU writes its return PC to on ISR entry
- MASK_ADDR, 14'h3FF0, snooped write here loads the enable mask
- EOI_ADDR, 14'h3FF1, snooped write here ends service of the active interrupt

Ports:
- clk  in  1  system clock; all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- irq_src  in  N_SRC  raw interrupt requests; asynchronous, rising-edge significant
- snoop_we  in  1  CPU wrEn
- snoop_addr  in  14  CPU addr_toRAM
- snoop_data  in  32  CPU data_toRAM
- cpu_irq  out  1  drives CPU interrupt input
- active_valid  out  1  an interrupt is being serviced
- active_id  out  ID_W  index of the interrupt raised or being serviced
- pending  out  N_SRC  pending flags
- mask  out  N_SRC  enable mask; 1 = enabled

Behaviour:
- Reset (async, immediate):
  - sync flops, pending and mask are all zeros;
  - state = IDLE;
  - cpu_irq = 0, active_valid = 0, active_id = 0.
  - Reset mid-operation abandons any in-flight interrupt with no residue.
- Input synchronisation:
  - each irq_src bit passes through a 2-flop synchroniser plus a 3rd flop for edge detect;
  - a rising edge sets pending[i] on the next posedge;
  - latency: irq_src rises before edge k → pending[i] = 1 after edge k+3;
  - a level held high sets pending only once; pulses shorter than one clock are not guaranteed.
- Mask writes:
  - snoop_we && snoop_addr==MASK_ADDR → mask <= snoop_data[N_SRC-1:0] on the next edge;
  - accepted in any state;
  - the mask gates only arbitration; pending bits are set regardless of mask.
- Priority: the lowest index among (pending & mask) wins.
- IDLE:
  - if (pending & mask) != 0: latch the winner into active_id, set cpu_irq = 1, go to RAISED (one cycle after the qualifying pending appears);
  - otherwise hold.
- RAISED:
  - cpu_irq is held 1;
  - a mask change or a higher-priority arrival does NOT retarget or withdraw the request (the CPU may already have latched it);
  - on snoop_we && snoop_addr==SAVE_ADDR: clear pending[active_id], set cpu_irq = 0, set active_valid = 1, go to SERVICE.
- SERVICE:
  - cpu_irq = 0, so the CPU does not re-latch after its return;
  - on snoop_we && snoop_addr==EOI_ADDR: set active_valid = 0, go to IDLE;
  - a new arbitration is possible on the following cycle;
  - snoop_data is ignored for EOI.
- Ignored events:
  - SAVE_ADDR writes in IDLE/SERVICE are ignored; they are normal RAM writes;
  - EOI writes in IDLE/RAISED are ignored.
- Simultaneous events:
  - new edge on pending[active_id] in the same cycle as its clear → pending stays set (set wins);
  - mask write and arbitration in the same cycle → arbitration uses the old mask.
- active_id holds its value after EOI until the next arbitration.
- Only one interrupt is in flight; there is no nesting.
- Outputs are registered except pending/mask, which are the state registers themselves.

Test Plan:
- Reset then mask write 0xFF; pulse irq_src[3] for 2 cycles → pending = 0x08 at edge +3, cpu_irq = 1 and active_id = 3 one cycle later. Snoop write to 0x0015 → cpu_irq = 0, active_valid = 1, pending = 0x00. Write to 0x3FF1 → active_valid = 0, state IDLE.
- Mask 0xFF; irq_src[5] and irq_src[2] rise in the same cycle → active_id = 2. After SAVE and EOI, the next arbitration gives active_id = 5 with cpu_irq = 1.
- Mask 0x00; pulse irq_src[1] → pending = 0x02, cpu_irq stays 0. Write mask 0x02 → cpu_irq = 1 two cycles after the mask write, active_id = 1.
- In RAISED with id 4, write mask 0x00 and raise irq_src[0] → cpu_irq stays 1, active_id stays 4, pending = 0x11. SAVE clears bit 4 → pending = 0x01.
- In SERVICE for id 6, irq_src[6] edge coincides with nothing, then write 0x3FF1; also write 0x0015 while in SERVICE → no effect. After EOI, id 6 re-raises.
- Assert rst asynchronously in RAISED (mid-cycle) → cpu_irq, active_valid, pending and mask go to 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/irq_ctrl.sv
// Prioritised interrupt controller: merges N_SRC edge-triggered sources into one CPU
// interrupt line and snoops CPU RAM writes for mask, ISR-entry save and EOI events.
module irq_ctrl #(
  parameter int          N_SRC     = 8,
  parameter int          ID_W      = 3,
  parameter logic [13:0] SAVE_ADDR = 14'h0015,
  parameter logic [13:0] MASK_ADDR = 14'h3FF0,
  parameter logic [13:0] EOI_ADDR  = 14'h3FF1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_SRC-1:0] irq_src,
  input  logic             snoop_we,
  input  logic [13:0]      snoop_addr,
  input  logic [31:0]      snoop_data,
  output logic             cpu_irq,
  output logic             active_valid,
  output logic [ID_W-1:0]  active_id,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic [1:0] {IDLE, RAISED, SERVICE} state_t;

  state_t           state, state_nxt;
  logic [N_SRC-1:0] sync1, sync2, hist, rise;
  logic [N_SRC-1:0] req, clr;
  logic [ID_W-1:0]  win_id, id_nxt;
  logic             win_vld, irq_nxt, valid_nxt;
  logic             mask_wr, save_wr, eoi_wr;
  logic             unused_data;

  assign unused_data = ^snoop_data[31:N_SRC];

  assign mask_wr = snoop_we && (snoop_addr == MASK_ADDR);
  assign save_wr = snoop_we && (snoop_addr == SAVE_ADDR);
  assign eoi_wr  = snoop_we && (snoop_addr == EOI_ADDR);

  // Two synchroniser flops, a history flop, and a registered rising-edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
      rise  <= '0;
    end else begin
      sync1 <= irq_src;
      sync2 <= sync1;
      hist  <= sync2;
      rise  <= sync2 & ~hist;
    end
  end

  assign req = pending & mask;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    win_id  = '0;
    win_vld = |req;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req[i]) win_id = ID_W'(i);
  end

  always_comb begin
    state_nxt = state;
    irq_nxt   = cpu_irq;
    valid_nxt = active_valid;
    id_nxt    = active_id;
    clr       = '0;
    case (state)
      IDLE: begin
        if (win_vld) begin
          id_nxt    = win_id;
          irq_nxt   = 1'b1;
          state_nxt = RAISED;
        end
      end
      RAISED: begin
        // Request is never retargeted once raised; the CPU may already hold it.
        if (save_wr) begin
          clr       = N_SRC'(1) << active_id;
          irq_nxt   = 1'b0;
          valid_nxt = 1'b1;
          state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        if (eoi_wr) begin
          valid_nxt = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        irq_nxt   = 1'b0;
        valid_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cpu_irq      <= 1'b0;
      active_valid <= 1'b0;
      active_id    <= '0;
      pending      <= '0;
      mask         <= '0;
    end else begin
      state        <= state_nxt;
      cpu_irq      <= irq_nxt;
      active_valid <= valid_nxt;
      active_id    <= id_nxt;
      // A fresh edge on the bit being cleared keeps it pending.
      pending      <= (pending & ~clr) | rise;
      if (mask_wr) mask <= snoop_data[N_SRC-1:0];
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: edge latency, priority, masking, no-retarget,
// ignored snoops, re-raise after EOI and asynchronous reset.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  irq_src;
  logic        snoop_we;
  logic [13:0] snoop_addr;
  logic [31:0] snoop_data;
  logic        cpu_irq, active_valid;
  logic [2:0]  active_id;
  logic [7:0]  pending, mask;

  int checks = 0;
  int failures = 0;

  irq_ctrl dut (
    .clk(clk), .rst(rst), .irq_src(irq_src),
    .snoop_we(snoop_we), .snoop_addr(snoop_addr), .snoop_data(snoop_data),
    .cpu_irq(cpu_irq), .active_valid(active_valid), .active_id(active_id),
    .pending(pending), .mask(mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; land 1 ns after it for both sampling and driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic snoop(input logic [13:0] a, input logic [31:0] d);
    snoop_we = 1'b1; snoop_addr = a; snoop_data = d;
    tick();
    snoop_we = 1'b0; snoop_addr = '0; snoop_data = '0;
  endtask

  // Two-cycle pulse; returns after the edge at which pending is first visible.
  task automatic pulse(input logic [7:0] bits);
    irq_src = bits;
    tick(); tick();
    irq_src = '0;
    tick(); tick();
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; snoop_we = 1'b0; snoop_addr = '0; snoop_data = '0;
    #23;
    chk("rst_irq",     cpu_irq, 0);
    chk("rst_valid",   active_valid, 0);
    chk("rst_id",      active_id, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mask",    mask, 0);
    rst = 1'b0;
    tick();

    // Basic flow on source 3
    snoop(14'h3FF0, 32'hFF);
    chk("t1_mask", mask, 8'hFF);
    irq_src = 8'h08;
    tick(); tick();
    irq_src = '0;
    tick();
    chk("t1_pend_e3", pending, 8'h00);
    tick();
    chk("t1_pend_e4", pending, 8'h08);
    chk("t1_irq_e4", cpu_irq, 0);
    tick();
    chk("t1_irq", cpu_irq, 1);
    chk("t1_id", active_id, 3);
    snoop(14'h0015, 32'h1234);
    chk("t1_save_irq", cpu_irq, 0);
    chk("t1_save_valid", active_valid, 1);
    chk("t1_save_pend", pending, 8'h00);
    snoop(14'h3FF1, 32'h0);
    chk("t1_eoi_valid", active_valid, 0);
    tick();
    chk("t1_idle_irq", cpu_irq, 0);

    // Simultaneous 5 and 2: lower index first, then 5
    pulse(8'h24);
    chk("t2_pend", pending, 8'h24);
    tick();
    chk("t2_irq", cpu_irq, 1);
    chk("t2_id", active_id, 2);
    snoop(14'h0015, 32'h0);
    chk("t2_pend_save", pending, 8'h20);
    snoop(14'h3FF1, 32'h0);
    chk("t2_eoi_irq", cpu_irq, 0);
    chk("t2_eoi_id_hold", active_id, 2);
    tick();
    chk("t2_irq5", cpu_irq, 1);
    chk("t2_id5", active_id, 5);
    snoop(14'h0015, 32'h0);
    snoop(14'h3FF1, 32'h0);
    chk("t2_clean", pending, 8'h00);

    // Masked source, then enable it
    snoop(14'h3FF0, 32'h00);
    pulse(8'h02);
    chk("t3_pend", pending, 8'h02);
    tick();
    chk("t3_masked_irq", cpu_irq, 0);
    snoop(14'h3FF0, 32'hFFFF_FF02);
    chk("t3_mask", mask, 8'h02);
    chk("t3_irq_early", cpu_irq, 0);
    tick();
    chk("t3_irq", cpu_irq, 1);
    chk("t3_id", active_id, 1);
    snoop(14'h0015, 32'h0);
    snoop(14'h3FF1, 32'h0);

    // No retarget while raised
    snoop(14'h3FF0, 32'hFF);
    pulse(8'h10);
    tick();
    chk("t4_id", active_id, 4);
    snoop(14'h3FF0, 32'h00);
    pulse(8'h01);
    chk("t4_pend", pending, 8'h11);
    chk("t4_irq_hold", cpu_irq, 1);
    chk("t4_id_hold", active_id, 4);
    snoop(14'h0015, 32'h0);
    chk("t4_pend_save", pending, 8'h01);
    chk("t4_valid", active_valid, 1);
    snoop(14'h3FF1, 32'h0);

    // Ignored events in SERVICE, re-raise after EOI
    snoop(14'h3FF0, 32'h40);
    snoop(14'h3FF1, 32'h0);
    chk("t5_eoi_idle_ign", active_valid, 0);
    pulse(8'h40);
    tick();
    chk("t5_irq", cpu_irq, 1);
    chk("t5_id", active_id, 6);
    snoop(14'h3FF1, 32'h0);
    chk("t5_eoi_raised_ign", cpu_irq, 1);
    snoop(14'h0015, 32'h0);
    chk("t5_pend_save", pending, 8'h01);
    pulse(8'h40);
    chk("t5_pend_svc", pending, 8'h41);
    chk("t5_irq_svc", cpu_irq, 0);
    snoop(14'h0015, 32'h0);
    chk("t5_save_ign_valid", active_valid, 1);
    chk("t5_save_ign_pend", pending, 8'h41);
    snoop(14'h3FF1, 32'h0);
    chk("t5_eoi_valid", active_valid, 0);
    chk("t5_id_hold", active_id, 6);
    tick();
    chk("t5_reraise", cpu_irq, 1);
    chk("t5_reraise_id", active_id, 6);

    // Async reset mid-cycle while raised
    #2 rst = 1'b1;
    #1;
    chk("t6_irq", cpu_irq, 0);
    chk("t6_valid", active_valid, 0);
    chk("t6_pend", pending, 0);
    chk("t6_mask", mask, 0);
    chk("t6_id", active_id, 0);
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("t6_post_irq", cpu_irq, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
